// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: framebuffer window placement and the
// arbiter grant encoding.
package cpu_pkg;

   localparam logic [14:0] SCREEN_BASE  = 15'h4000;
   localparam int          SCREEN_WORDS = 8192;

   typedef enum logic [1:0] {
      G_IDLE,
      G_VGA,
      G_WR
   } t_fb_grant;

endpackage

// File: rtl/fb_arbiter_if.sv
// Bundle of CPU write mirror, VGA read port, RAM port and status signals.
// The arbiter takes the slave side; the surrounding system takes the master side.
interface fb_arbiter_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16,
   parameter int FB_AW  = 13,
   parameter int DEPTH  = 8
) ();
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic              Clear;
   logic              CpuWrEn;
   logic [ADDR_W-1:0] CpuAddr;
   logic [DATA_W-1:0] CpuData;
   logic              VgaRdReq;
   logic [FB_AW-1:0]  VgaRdAddr;
   logic              VgaRdValid;
   logic [DATA_W-1:0] VgaRdData;
   logic [FB_AW-1:0]  FbAddr;
   logic [DATA_W-1:0] FbWrData;
   logic              FbWrEn;
   logic              FbRdEn;
   logic [DATA_W-1:0] FbRdData;
   logic [LVL_W-1:0]  Level;
   logic              Overflow;
   logic [7:0]        DropCount;

   modport master (
      output Clear, CpuWrEn, CpuAddr, CpuData, VgaRdReq, VgaRdAddr, FbRdData,
      input  VgaRdValid, VgaRdData, FbAddr, FbWrData, FbWrEn, FbRdEn,
             Level, Overflow, DropCount
   );

   modport slave (
      input  Clear, CpuWrEn, CpuAddr, CpuData, VgaRdReq, VgaRdAddr, FbRdData,
      output VgaRdValid, VgaRdData, FbAddr, FbWrData, FbWrEn, FbRdEn,
             Level, Overflow, DropCount
   );

endinterface

// File: rtl/fb_wr_fifo.sv
// Address/data write queue with in-place coalescing on the newest entry.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module fb_wr_fifo #(
   parameter int FB_AW  = 13,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      clear,
   input  logic                      push,
   input  logic                      pop,
   input  logic [FB_AW-1:0]          push_addr,
   input  logic [DATA_W-1:0]         push_data,
   output logic [FB_AW-1:0]          head_addr,
   output logic [DATA_W-1:0]         head_data,
   output logic                      empty,
   output logic                      full,
   output logic                      push_drop,
   output logic [$clog2(DEPTH):0]    level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FB_AW-1:0]   addr_mem [DEPTH];
   logic [DATA_W-1:0]  data_mem [DEPTH];
   logic [AW-1:0]      newest_idx, mem_idx;
   logic               mem_we, coalesce, accept;

   always_comb begin
      level      = wr_ptr_q - rd_ptr_q;
      empty      = (level == '0);
      full       = (level == (AW+1)'(DEPTH));
      newest_idx = wr_ptr_q[AW-1:0] - AW'(1);
      head_addr  = addr_mem[rd_ptr_q[AW-1:0]];
      head_data  = data_mem[rd_ptr_q[AW-1:0]];
      // The newest entry is off-limits for merging when it is also the head being popped.
      coalesce   = push && !empty && (addr_mem[newest_idx] == push_addr)
                   && !(pop && level == PTR_ONE);
      accept     = push && !coalesce && (!full || pop);
      push_drop  = push && !coalesce && full && !pop && !clear;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_we   = 1'b0;
      mem_idx  = wr_ptr_q[AW-1:0];
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (coalesce) begin
            mem_we  = 1'b1;
            mem_idx = newest_idx;
         end else if (accept) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop && !empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (mem_we) begin
         addr_mem[mem_idx] <= push_addr;
         data_mem[mem_idx] <= push_data;
      end
   end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM port arbiter: VGA reads always win, screen-window CPU
// writes are queued and drained on idle cycles, overflowing writes are counted.
module fb_arbiter #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16,
   parameter int FB_AW  = 13,
   parameter int DEPTH  = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   fb_arbiter_if.slave bus
);
   import cpu_pkg::*;

   localparam int WIN_LO = int'(SCREEN_BASE);
   localparam int WIN_HI = WIN_LO + SCREEN_WORDS;

   logic [31:0]       cpu_addr_w;
   logic              in_win, pop, push_drop, fifo_empty, fifo_full;
   logic [FB_AW-1:0]  push_addr, head_addr;
   logic [DATA_W-1:0] head_data;
   t_fb_grant         grant;

   logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;
   logic [DATA_W-1:0] fb_wr_data_q, fb_wr_data_d;
   logic              fb_wr_en_q, fb_wr_en_d, fb_rd_en_q, fb_rd_en_d;
   logic              rd_valid_q, rd_valid_d, overflow_q, overflow_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;

   always_comb begin
      cpu_addr_w = 32'(bus.CpuAddr);
      in_win     = bus.CpuWrEn && (cpu_addr_w >= 32'(WIN_LO)) && (cpu_addr_w < 32'(WIN_HI));
      push_addr  = FB_AW'(bus.CpuAddr - ADDR_W'(SCREEN_BASE));

      // A clearing cycle issues no RAM write, since the pop it would need is discarded.
      grant = G_IDLE;
      if (bus.VgaRdReq)                     grant = G_VGA;
      else if (!fifo_empty && !bus.Clear)   grant = G_WR;
      pop = (grant == G_WR);

      fb_addr_d    = fb_addr_q;
      fb_wr_data_d = fb_wr_data_q;
      fb_wr_en_d   = 1'b0;
      fb_rd_en_d   = 1'b0;
      case (grant)
         G_VGA: begin
            fb_addr_d  = bus.VgaRdAddr;
            fb_rd_en_d = 1'b1;
         end
         G_WR: begin
            fb_addr_d    = head_addr;
            fb_wr_data_d = head_data;
            fb_wr_en_d   = 1'b1;
         end
         default: ;
      endcase
      rd_valid_d = fb_rd_en_q;

      drop_cnt_d = drop_cnt_q;
      overflow_d = overflow_q;
      if (bus.Clear) begin
         drop_cnt_d = '0;
         overflow_d = 1'b0;
      end else if (push_drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fb_addr_q    <= '0;
         fb_wr_data_q <= '0;
         fb_wr_en_q   <= 1'b0;
         fb_rd_en_q   <= 1'b0;
         rd_valid_q   <= 1'b0;
         overflow_q   <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         fb_addr_q    <= fb_addr_d;
         fb_wr_data_q <= fb_wr_data_d;
         fb_wr_en_q   <= fb_wr_en_d;
         fb_rd_en_q   <= fb_rd_en_d;
         rd_valid_q   <= rd_valid_d;
         overflow_q   <= overflow_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   fb_wr_fifo #(
      .FB_AW  (FB_AW),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .Clk       (Clk),
      .Reset     (Reset),
      .clear     (bus.Clear),
      .push      (in_win),
      .pop       (pop),
      .push_addr (push_addr),
      .push_data (bus.CpuData),
      .head_addr (head_addr),
      .head_data (head_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .push_drop (push_drop),
      .level     (bus.Level)
   );

   assign bus.FbAddr     = fb_addr_q;
   assign bus.FbWrData   = fb_wr_data_q;
   assign bus.FbWrEn     = fb_wr_en_q;
   assign bus.FbRdEn     = fb_rd_en_q;
   assign bus.VgaRdValid = rd_valid_q;
   assign bus.VgaRdData  = bus.FbRdData;
   assign bus.Overflow   = overflow_q;
   assign bus.DropCount  = drop_cnt_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: reset, write path, VGA priority, overflow,
// coalescing, full-with-pop, drop saturation and asynchronous reset.
module tb_fb_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   fb_arbiter_if bus ();

   fb_arbiter dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_wr(input logic [14:0] a, input logic [15:0] d);
      bus.CpuWrEn = 1'b1;
      bus.CpuAddr = a;
      bus.CpuData = d;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [14:0] oow [3];
      logic [14:0] inw [2];
      logic [12:0] inw_exp [2];
      oow = '{15'h0010, 15'h3FFF, 15'h6000};
      inw = '{15'h4000, 15'h5FFF};
      inw_exp = '{13'h0000, 13'h1FFF};

      bus.Clear     = 1'b0;
      bus.CpuWrEn   = 1'b0;
      bus.CpuAddr   = '0;
      bus.CpuData   = '0;
      bus.VgaRdReq  = 1'b0;
      bus.VgaRdAddr = '0;
      bus.FbRdData  = 16'h1234;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset / idle
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("reset_idle", 64'({bus.FbAddr, bus.FbWrData, bus.FbWrEn, bus.FbRdEn, bus.VgaRdValid,
                                bus.Level, bus.Overflow, bus.DropCount}), 64'h0);
      end
      chk("rd_passthru", bus.VgaRdData, 16'h1234);

      // Single write
      cpu_wr(15'h4005, 16'hBEEF);
      tick();
      bus.CpuWrEn = 1'b0;
      chk("wr_t1_en", bus.FbWrEn, 0);
      chk("wr_t1_level", bus.Level, 1);
      tick();
      chk("wr_t2_en", bus.FbWrEn, 1);
      chk("wr_t2_addr", bus.FbAddr, 5);
      chk("wr_t2_data", bus.FbWrData, 16'hBEEF);
      chk("wr_t2_level", bus.Level, 0);
      tick();
      chk("wr_t3_en", bus.FbWrEn, 0);

      // Window edges
      for (int i = 0; i < 3; i++) begin
         cpu_wr(oow[i], 16'h1111);
         tick();
         bus.CpuWrEn = 1'b0;
         chk("oow_level", bus.Level, 0);
         tick();
         chk("oow_en", bus.FbWrEn, 0);
      end
      for (int i = 0; i < 2; i++) begin
         cpu_wr(inw[i], 16'h7770 + 16'(i));
         tick();
         bus.CpuWrEn = 1'b0;
         tick();
         chk("inw_en", bus.FbWrEn, 1);
         chk("inw_addr", bus.FbAddr, inw_exp[i]);
         chk("inw_data", bus.FbWrData, 16'h7770 + 16'(i));
      end
      tick();

      // VGA priority with three queued writes
      for (int i = 0; i < 10; i++) begin
         bus.VgaRdReq  = 1'b1;
         bus.VgaRdAddr = 13'(100 + i);
         bus.FbRdData  = 16'hC000 | 16'(i);
         if (i < 3) cpu_wr(15'h4100 + 15'(i), 16'h00A1 + 16'(i));
         else       bus.CpuWrEn = 1'b0;
         tick();
         chk("vga_rden", bus.FbRdEn, 1);
         chk("vga_addr", bus.FbAddr, 13'(100 + i));
         chk("vga_wren", bus.FbWrEn, 0);
         chk("vga_valid", bus.VgaRdValid, (i >= 1));
         if (i >= 1) chk("vga_data", bus.VgaRdData, 16'hC000 | 16'(i));
      end
      chk("vga_level", bus.Level, 3);
      bus.VgaRdReq = 1'b0;
      tick();
      chk("vga_last_valid", bus.VgaRdValid, 1);
      chk("vga_last_rden", bus.FbRdEn, 0);
      for (int j = 0; j < 3; j++) begin
         if (j > 0) tick();
         chk("drain_en", bus.FbWrEn, 1);
         chk("drain_addr", bus.FbAddr, 13'h100 + 13'(j));
         chk("drain_data", bus.FbWrData, 16'h00A1 + 16'(j));
      end
      tick();
      chk("drain_done_en", bus.FbWrEn, 0);
      chk("drain_done_valid", bus.VgaRdValid, 0);
      chk("drain_done_level", bus.Level, 0);

      // Overflow then Clear
      bus.VgaRdReq  = 1'b1;
      bus.VgaRdAddr = '0;
      for (int i = 0; i < 11; i++) begin
         cpu_wr(15'h4200 + 15'(i), 16'h0200 + 16'(i));
         tick();
      end
      bus.CpuWrEn = 1'b0;
      chk("ovf_level", bus.Level, 8);
      chk("ovf_drops", bus.DropCount, 3);
      chk("ovf_flag", bus.Overflow, 1);
      bus.Clear = 1'b1;
      tick();
      bus.Clear = 1'b0;
      chk("clr_level", bus.Level, 0);
      chk("clr_drops", bus.DropCount, 0);
      chk("clr_flag", bus.Overflow, 0);
      bus.VgaRdReq = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("clr_no_wr", bus.FbWrEn, 0);
      end

      // Coalescing while the entry is held
      bus.VgaRdReq = 1'b1;
      cpu_wr(15'h4010, 16'd1);
      tick();
      chk("coal_level1", bus.Level, 1);
      cpu_wr(15'h4010, 16'd2);
      tick();
      chk("coal_level2", bus.Level, 1);
      bus.CpuWrEn  = 1'b0;
      bus.VgaRdReq = 1'b0;
      tick();
      chk("coal_en", bus.FbWrEn, 1);
      chk("coal_addr", bus.FbAddr, 13'h10);
      chk("coal_data", bus.FbWrData, 2);
      tick();
      chk("coal_single", bus.FbWrEn, 0);
      chk("coal_level0", bus.Level, 0);

      // Same address while the only entry is being popped: two writes
      cpu_wr(15'h4020, 16'd1);
      tick();
      cpu_wr(15'h4020, 16'd2);
      tick();
      bus.CpuWrEn = 1'b0;
      chk("nocoal_en1", bus.FbWrEn, 1);
      chk("nocoal_data1", bus.FbWrData, 1);
      tick();
      chk("nocoal_en2", bus.FbWrEn, 1);
      chk("nocoal_addr2", bus.FbAddr, 13'h20);
      chk("nocoal_data2", bus.FbWrData, 2);
      tick();
      chk("nocoal_done", bus.FbWrEn, 0);

      // Full: coalesce is not a drop, push with pop is accepted
      bus.VgaRdReq = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cpu_wr(15'h4300 + 15'(i), 16'h0300 + 16'(i));
         tick();
      end
      chk("full_level", bus.Level, 8);
      cpu_wr(15'h4307, 16'h03FF);
      tick();
      chk("full_coal_level", bus.Level, 8);
      chk("full_coal_drops", bus.DropCount, 0);
      chk("full_coal_flag", bus.Overflow, 0);
      bus.VgaRdReq = 1'b0;
      cpu_wr(15'h4400, 16'h0055);
      tick();
      bus.CpuWrEn = 1'b0;
      chk("fullpop_level", bus.Level, 8);
      chk("fullpop_drops", bus.DropCount, 0);
      chk("fullpop_en", bus.FbWrEn, 1);
      chk("fullpop_addr", bus.FbAddr, 13'h300);
      for (int j = 1; j < 9; j++) begin
         tick();
         chk("fullpop_drain_en", bus.FbWrEn, 1);
         chk("fullpop_drain_addr", bus.FbAddr, (j < 8) ? 13'h300 + 13'(j) : 13'h400);
         chk("fullpop_drain_data", bus.FbWrData,
             (j < 7) ? 16'h0300 + 16'(j) : ((j == 7) ? 16'h03FF : 16'h0055));
      end
      tick();
      chk("fullpop_done_en", bus.FbWrEn, 0);
      chk("fullpop_done_level", bus.Level, 0);

      // Drop counter saturation
      bus.VgaRdReq = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cpu_wr(15'h4500 + 15'(i), 16'h0500);
         tick();
      end
      for (int i = 0; i < 300; i++) begin
         cpu_wr(15'h4600 + 15'(i), 16'hDEAD);
         tick();
         if (i == 253) chk("sat_254", bus.DropCount, 254);
      end
      bus.CpuWrEn = 1'b0;
      chk("sat_255", bus.DropCount, 255);
      chk("sat_flag", bus.Overflow, 1);
      chk("sat_level", bus.Level, 8);

      // Asynchronous reset mid-operation
      chk("pre_rst_rden", bus.FbRdEn, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst", 64'({bus.FbAddr, bus.FbWrData, bus.FbWrEn, bus.FbRdEn, bus.VgaRdValid,
                            bus.Level, bus.Overflow, bus.DropCount}), 64'h0);
      bus.VgaRdReq = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_no_wr", bus.FbWrEn, 0);
         chk("post_rst_level", bus.Level, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Shares the single-port framebuffer RAM between the CPU's mirrored data-memory write stream (`out_m`/`write_m`/`data_addr`) and the VGA scanout reader. CPU writes that fall in the screen window are queued in a small FIFO and drained whenever the VGA reader is idle. VGA reads always win, so scanout deadlines are met. The CPU cannot be stalled, so writes that arrive while the queue is full are dropped and counted.

## Interface
- `ADDR_W`, default 15: CPU data-address width.
- `DATA_W`, default 16: data width.
- `FB_AW`, default 13: framebuffer word-address width.
- `DEPTH`, default 8: write FIFO entries (power of two, ≥2).

Ports:
- `Clk`  in  1  single clock.
- `Reset`  in  1  asynchronous, active-high.
- `Clear`  in  1  sync: empty FIFO, zero `DropCount`, clear `Overflow`.
- `CpuWrEn`  in  1  mirrored CPU write strobe (`write_m`).
- `CpuAddr`  in  `ADDR_W`  mirrored `data_addr`.
- `CpuData`  in  `DATA_W`  mirrored `out_m`.
- `VgaRdReq`  in  1  read request, single-cycle, no ready.
- `VgaRdAddr`  in  `FB_AW`  read word address.
- `VgaRdValid`  out  1  read data valid.
- `VgaRdData`  out  `DATA_W`  read data.
- `FbAddr`  out  `FB_AW`  RAM address (registered).
- `FbWrData`  out  `DATA_W`  RAM write data (registered).
- `FbWrEn`  out  1  RAM write enable (registered).
- `FbRdEn`  out  1  RAM read enable (registered).
- `FbRdData`  in  `DATA_W`  RAM read data, 1-cycle synchronous latency.
- `Level`  out  `$clog2(DEPTH)+1`  FIFO occupancy.
- `Overflow`  out  1  sticky: at least one write dropped.
- `DropCount`  out  8  dropped writes, saturates at 255.

## Operation
- Window filter: a write is queued only if `CpuWrEn` is high and `SCREEN_BASE ≤ CpuAddr < SCREEN_BASE+SCREEN_WORDS`. The stored address is `CpuAddr-SCREEN_BASE`, truncated to `FB_AW`. Out-of-window writes are ignored: not counted, not dropped.
- Per-cycle grant, priority order: `G_VGA` if `VgaRdReq`; else `G_WR` if FIFO non-empty; else `G_IDLE`. The grant is registered into the `Fb*` outputs. `G_WR` pops the FIFO head.
- Coalescing: if a queued write's address equals the newest FIFO entry and that entry is not being popped this cycle, overwrite its data in place. The entry count is unchanged.
- Push with FIFO full:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the write is dropped, `DropCount` increments (saturating) and `Overflow` sets.
  - Coalescing into a full FIFO is not a drop.
- `Clear` beats a simultaneous push, pop or drop.
- No read-after-write coherence: VGA may read a pixel whose update is still queued.

## Timing
- Reset values: `FbAddr`=0, `FbWrData`=0, `FbWrEn`=0, `FbRdEn`=0, `VgaRdValid`=0, `VgaRdData`=`FbRdData` (passthrough), `Level`=0, `Overflow`=0, `DropCount`=0. FIFO pointers are 0.
- VGA read:
  - `VgaRdReq` at cycle t gives `FbRdEn`/`FbAddr` at t+1.
  - `VgaRdValid` with `VgaRdData` follows at t+2.
  - Fixed latency of 2 whenever requested, with back-to-back requests allowed.
- CPU write:
  - A write arriving at t is written into the FIFO at the t/t+1 edge.
  - Earliest `FbWrEn` is at t+2 (head evaluated at t+1, registered).
  - Under continuous VGA requests the FIFO does not drain.
- `Level` updates one cycle after the push/pop edge.
- Reset asserted mid-operation forces all state to reset values immediately (asynchronous). Queued writes are lost.

## Structure
- `cpu_pkg` additions:
  - `SCREEN_BASE` = 15'h4000.
  - `SCREEN_WORDS` = 8192.
  - `typedef enum {G_IDLE, G_VGA, G_WR} t_fb_grant`.
- Sub-module `fb_wr_fifo`:
  - Holds address and data, with push, pop, coalesce, clear, full/empty and level.
  - Pointers carry one extra wrap bit.
- `fb_arbiter` contains the window filter, grant logic, output registers, drop counter and `Overflow` flag.

## Test plan
- Reset/idle: after reset release with no stimulus, all outputs hold their reset values for 20 cycles.
- Single write: `CpuWrEn` with `CpuAddr`=16'h4005 and `CpuData`=16'hBEEF at t, no VGA → `FbWrEn` with `FbAddr`=5 and `FbWrData`=16'hBEEF at t+2 only. Out-of-window `CpuAddr`=16'h0010 → no `FbWrEn`.
- VGA priority: 3 writes queued, then `VgaRdReq` for 10 cycles → `FbWrEn`=0 for those cycles. `VgaRdValid` runs t+2..t+11 with `FbRdData` passed through. The writes drain in order afterwards.
- Overflow: `DEPTH`+3 distinct in-window writes while VGA is held → `Level`=8, `DropCount`=3, `Overflow`=1. Then `Clear` → all three are 0.
- Coalescing: writes to 16'h4010 of 1 then 2 on consecutive cycles while the entry is not popped → a single `FbWrEn` with data 2, and `Level` peaks at 1.
- Full plus pop: FIFO full, VGA idle, new write → accepted, `DropCount` unchanged. 300 drops → `DropCount` saturates at 255.
